// File: rtl/l2_mem_arbiter.sv
// N-channel arbiter sharing one line-wide memory port among cache requesters.
// One whole-line transaction in flight at a time; round-robin or fixed priority.
module l2_mem_arbiter #(
  parameter int NCH       = 2,
  parameter int ADDR_W    = 28,
  parameter int LINE_W    = 128,
  parameter int PRIO_MODE = 0
) (
  input  logic                    clk,
  input  logic                    proc_reset,
  input  logic [NCH-1:0]          req_read,
  input  logic [NCH-1:0]          req_write,
  input  logic [NCH*ADDR_W-1:0]   req_addr,
  input  logic [NCH*LINE_W-1:0]   req_wdata,
  output logic [NCH-1:0]          req_ready,
  output logic [LINE_W-1:0]       req_rdata,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LINE_W-1:0]       mem_wdata,
  input  logic [LINE_W-1:0]       mem_rdata,
  input  logic                    mem_ready
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_q, last_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [NCH-1:0]      req_ready_q, req_ready_d;
  logic [LINE_W-1:0]   req_rdata_q, req_rdata_d;

  logic [NCH-1:0]      pend_s;
  logic                win_found_s;
  logic [GW-1:0]       win_idx_s;
  logic [GW-1:0]       scan_idx_s;
  logic [ADDR_W-1:0]   addr_arr_s  [NCH];
  logic [LINE_W-1:0]   wdata_arr_s [NCH];

  // Split the flat request buses into per-channel slices.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      addr_arr_s[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr_s[i] = req_wdata[i*LINE_W +: LINE_W];
    end
  end

  // Winner scan: candidates are visited from lowest to highest preference so
  // the last hit wins (lowest index in priority mode, nearest after last_q in RR).
  always_comb begin
    pend_s      = req_read | req_write;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    scan_idx_s  = '0;
    for (int k = NCH; k >= 1; k--) begin
      if (PRIO_MODE == 1) begin
        scan_idx_s = GW'(k - 1);
      end else begin
        scan_idx_s = GW'((int'(last_q) + k) % NCH);
      end
      if (pend_s[scan_idx_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = scan_idx_s;
      end else begin
        win_found_s = win_found_s;
        win_idx_s   = win_idx_s;
      end
    end
  end

  // Next-state and next-output computation for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    req_ready_d = '0;
    req_rdata_d = req_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (win_found_s) begin
          state_d     = S_BUSY;
          grant_d     = win_idx_s;
          if (PRIO_MODE == 0) begin
            last_d = win_idx_s;
          end else begin
            last_d = last_q;
          end
          // A write wins over a simultaneous read on the same channel.
          mem_write_d = req_write[win_idx_s];
          mem_read_d  = ~req_write[win_idx_s];
          mem_addr_d  = addr_arr_s[win_idx_s];
          mem_wdata_d = wdata_arr_s[win_idx_s];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          state_d     = S_DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          for (int i = 0; i < NCH; i++) begin
            req_ready_d[i] = (grant_q == GW'(i));
          end
          if (mem_read_q) begin
            req_rdata_d = mem_rdata;
          end else begin
            req_rdata_d = req_rdata_q;
          end
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      last_q      <= GW'(NCH - 1);
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      req_ready_q <= '0;
      req_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      req_ready_q <= req_ready_d;
      req_rdata_q <= req_rdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign req_rdata = req_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/l2_mem_arbiter.md
# l2_mem_arbiter

Parametrised N-channel arbiter that shares one slow-memory block port among several cache-side requesters (L1 I-cache, L1/L2 D-cache, future cores). It replaces today's fixed one-memory-per-cache wiring under the top-level chip. It latches one whole-line read or write transaction at a time, forwards it to memory, and returns completion to the granted channel. Channel selection is round-robin or fixed-priority.

## Interface
Parameters:
- NCH, 2, number of requester channels (≥1)
- ADDR_W, 28, line address width (byte address bits [31:4])
- LINE_W, 128, line data width
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)

Ports:
- clk  in  1  system clock, all state on rising edge
- proc_reset  in  1  synchronous, active-high reset
- req_read  in  NCH  per-channel line read request, held until req_ready
- req_write  in  NCH  per-channel line write request, held until req_ready
- req_addr  in  NCH*ADDR_W  channel i address at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NCH*LINE_W  channel i write line at [i*LINE_W +: LINE_W]
- req_ready  out  NCH  one-hot, one-cycle completion pulse to granted channel
- req_rdata  out  LINE_W  read line shared by all channels, valid while req_ready pulses
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory line address
- mem_wdata  out  LINE_W  memory write line
- mem_rdata  in  LINE_W  memory read line, valid with mem_ready
- mem_ready  in  1  memory completion pulse

## Operation
- Channel i is pending when req_read[i] | req_write[i]. If both are set, the transaction is a write; the read is not serviced.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If no channel is pending, stay in IDLE.
  - Otherwise pick winner g, register g, op (read/write), req_addr slice and req_wdata slice, and go to BUSY.
- Winner selection:
  - PRIO_MODE=0: first pending channel scanning from (last_grant+1) mod NCH upward with wrap. last_grant updates to g on grant.
  - PRIO_MODE=1: lowest pending index; last_grant is unused.
- BUSY:
  - mem_read = registered op==read; mem_write = registered op==write.
  - mem_addr and mem_wdata come from the registered values and stay stable for the whole state.
  - On mem_ready: capture mem_rdata into the rdata register (reads only; writes leave it unchanged) and go to DONE.
- DONE:
  - mem_read = mem_write = 0.
  - req_ready[g] = 1; all other req_ready bits are 0.
  - Next state is IDLE unconditionally.
- The request is latched at grant. A requester dropping or changing its request during BUSY does not affect the transaction in flight.
- mem_ready outside BUSY is ignored.
- NCH=1 degenerates to a registered pass-through with the same timing.
- Reset: proc_reset in any state forces IDLE. A memory transaction in flight is abandoned, with no req_ready pulse.

## Timing
- Reset values:
  - req_ready = 0, mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0, req_rdata = 0.
  - last_grant = NCH-1, so channel 0 is served first after reset.
- All outputs are registered or decoded from registered state only. There is no combinational path from req_* or mem_ready to any output.
- Sequence for a request first seen at cycle t in IDLE:
  - mem strobe is high from t+1.
  - If mem_ready arrives at cycle m, req_ready[g] and req_rdata are valid at m+1 (DONE) for exactly one cycle.
  - The arbiter is back in IDLE at m+2 and can grant again at m+2; the next mem strobe rises at m+3.
- Arbiter overhead is 2 cycles per transaction plus memory latency.
- Requesters must deassert or change their request by the cycle after req_ready. A request still held at m+2 is treated as a new transaction.
- Round-robin fairness: with all NCH channels continuously pending, every channel is granted exactly once in any NCH consecutive grants.

## Test plan
- Single read, NCH=2: ch1 read addr 0x0000123, memory answers mem_ready after 5 cycles with line 0xA5..A5. Required: mem_read is high for those cycles with mem_addr=0x0000123, then req_ready=2'b10 for one cycle with req_rdata=0xA5..A5; mem strobe is low in that cycle.
- Simultaneous requests, PRIO_MODE=0: ch0 read and ch1 write both asserted from reset release and held. Required: grant order ch0, ch1, ch0, ch1; ch1 is issued as mem_write with its req_wdata.
- Same stimulus with PRIO_MODE=1 and ch0 re-requesting immediately after each req_ready. Required: ch0 is granted every time and ch1 waits (starvation is intentional).
- Read and write both set on ch0 with addr 0x0ABCDEF. Required: only mem_write is issued; req_rdata is unchanged from its previous value.
- Request withdrawn mid-flight: ch0 drops req_read 2 cycles after grant. Required: mem_read stays high until mem_ready, then a req_ready[0] pulse occurs, and no second transaction is started.
- Reset mid-operation: assert proc_reset during BUSY. Required: the next cycle has mem_read = mem_write = 0 and req_ready = 0. After release, with ch1 and ch0 both pending, ch0 is granted first.
